alu_share_arbiter: RTL and testbench

//  Shares the single combinational ALU between NUM_REQ requesters (e.g. decode lanes, address-gen, branch unit).

---
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin front end that lets NUM_REQ requesters share one combinational
// ALU. One op is issued per cycle into a single-entry response slot, and each
// requester keeps its own carry so interleaved ADDC/SUBC chains stay separate.
module alu_share_arbiter #(
    parameter int NUM_REQ          = 3,
    parameter int DATABUS_SIZE     = 32,
    parameter int ALU_CONTROL_SIZE = 5,
    parameter logic [ALU_CONTROL_SIZE-1:0] OP_ADD  = ALU_CONTROL_SIZE'(0),
    parameter logic [ALU_CONTROL_SIZE-1:0] OP_SUB  = ALU_CONTROL_SIZE'(1),
    parameter logic [ALU_CONTROL_SIZE-1:0] OP_ADDC = ALU_CONTROL_SIZE'(2),
    parameter logic [ALU_CONTROL_SIZE-1:0] OP_SUBC = ALU_CONTROL_SIZE'(3)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*ALU_CONTROL_SIZE-1:0]   req_op,
    input  logic [NUM_REQ*DATABUS_SIZE-1:0]       req_a,
    input  logic [NUM_REQ*DATABUS_SIZE-1:0]       req_b,
    output logic [DATABUS_SIZE-1:0]               alu_input1,
    output logic [DATABUS_SIZE-1:0]               alu_input2,
    output logic [ALU_CONTROL_SIZE-1:0]           alu_control,
    output logic                                  alu_carry_in,
    input  logic [DATABUS_SIZE-1:0]               alu_Z,
    input  logic [3:0]                            alu_flags,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]            rsp_id,
    output logic [DATABUS_SIZE-1:0]               rsp_data,
    output logic [3:0]                            rsp_flags
);

    localparam int IDW = $clog2(NUM_REQ);

    logic                    rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]          rsp_id_q, rsp_id_d;
    logic [DATABUS_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]              rsp_flags_q, rsp_flags_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      carry_q, carry_d;

    logic                    can_issue;
    logic                    issue;
    logic                    grant_found;
    logic [IDW-1:0]          grant_idx;
    logic [IDW:0]            scan_idx;
    logic                    carry_op;

    // Search upward from rr_ptr (wrapping) for the first pending requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    // The slot can take a new result when empty or when it drains this cycle.
    assign can_issue = !rsp_valid_q || rsp_ready;
    assign issue     = !reset && can_issue && grant_found;

    // One-hot grant and ALU operand steering; everything is zero when idle.
    always_comb begin
        req_ready    = '0;
        alu_input1   = '0;
        alu_input2   = '0;
        alu_control  = '0;
        alu_carry_in = 1'b0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
            alu_input1   = req_a[int'(grant_idx)*DATABUS_SIZE +: DATABUS_SIZE];
            alu_input2   = req_b[int'(grant_idx)*DATABUS_SIZE +: DATABUS_SIZE];
            alu_control  = req_op[int'(grant_idx)*ALU_CONTROL_SIZE +: ALU_CONTROL_SIZE];
            alu_carry_in = carry_q[grant_idx];
        end
    end

    assign carry_op = (alu_control == OP_ADD)  || (alu_control == OP_SUB) ||
                      (alu_control == OP_ADDC) || (alu_control == OP_SUBC);

    // Next state: issue overwrites the slot, a bare pop just clears valid.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rr_ptr_d    = rr_ptr_q;
        carry_d     = carry_q;
        if (issue) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = alu_Z;
            rsp_flags_d = alu_flags;
            rr_ptr_d    = (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
            if (carry_op) begin
                carry_d[grant_idx] = alu_flags[1];
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rr_ptr_q    <= '0;
            carry_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rr_ptr_q    <= rr_ptr_d;
            carry_q     <= carry_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with NUM_REQ=3, DATABUS_SIZE=8 and a behavioural
// ALU. Opcodes: 0 ADD, 1 SUB, 2 ADDC, 3 SUBC, 4 AND, 5 OR, 6 XOR.
module tb_alu_share_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] flags;
        logic [7:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [14:0] req_op = '0;
    logic [23:0] req_a = '0;
    logic [23:0] req_b = '0;
    logic [7:0]  alu_input1, alu_input2, alu_Z;
    logic [4:0]  alu_control;
    logic        alu_carry_in;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_flags;

    int total = 0;
    int bad   = 0;

    rsp_t       sb_q[$];
    logic [1:0] m_ptr   = '0;
    logic [2:0] m_carry = '0;
    logic       m_full  = 1'b0;
    logic       m_pend  = 1'b0;
    rsp_t       m_last  = '0;

    alu_share_arbiter #(
        .NUM_REQ(3), .DATABUS_SIZE(8), .ALU_CONTROL_SIZE(5)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_control(alu_control), .alu_carry_in(alu_carry_in),
        .alu_Z(alu_Z), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags)
    );

    always #5 clk = ~clk;

    // Returns {SIGN,OVF,CARRY,ZERO, Z}; carry on subtract means "no borrow".
    function automatic logic [11:0] alu_ref(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic [7:0] z;
        logic       c;
        logic       v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            5'd0: s = {1'b0, a} + {1'b0, b};
            5'd1: s = {1'b0, a} + {1'b0, ~b} + 9'd1;
            5'd2: s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            5'd3: s = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
            5'd4: s = {1'b0, a & b};
            5'd5: s = {1'b0, a | b};
            5'd6: s = {1'b0, a ^ b};
            default: s = {1'b0, a};
        endcase
        z = s[7:0];
        if (op <= 5'd3) begin
            c = s[8];
            if (op[0] == 1'b0) v = (a[7] == b[7]) && (z[7] != a[7]);
            else               v = (a[7] != b[7]) && (z[7] != a[7]);
        end
        return {z[7], v, c, (z == 8'd0), z};
    endfunction

    always_comb {alu_flags, alu_Z} = alu_ref(alu_control, alu_input1, alu_input2, alu_carry_in);

    task automatic set_req(input int i, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[i*5 +: 5] = op;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
    endtask

    // Scoreboard: predict grants, push expected results, pop them a cycle later.
    always @(negedge clk) begin
        rsp_t       e;
        logic [2:0] exp_ready;
        logic       found;
        int         g;
        logic [4:0] op;
        logic [7:0] a, b;
        logic [11:0] r;
        total++;
        if (rsp_valid !== m_full) begin
            bad++;
            $display("FAIL sb_rsp_valid: got %b want %b at %0t", rsp_valid, m_full, $time);
        end
        if (m_pend) begin
            e = sb_q.pop_front();
            m_last = e;
        end
        total++;
        if ({rsp_id, rsp_flags, rsp_data} !== m_last) begin
            bad++;
            $display("FAIL sb_rsp: got id=%0d flags=%h data=%h want id=%0d flags=%h data=%h at %0t",
                     rsp_id, rsp_flags, rsp_data, m_last.id, m_last.flags, m_last.data, $time);
        end
        m_pend = 1'b0;
        if (reset) begin
            m_full = 1'b0; m_ptr = '0; m_carry = '0; m_last = '0;
            sb_q.delete();
        end else begin
            found = 1'b0; g = 0;
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % 3;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g = idx;
                end
            end
            exp_ready = ((!m_full || rsp_ready) && found) ? 3'(1 << g) : 3'b000;
            total++;
            if (req_ready !== exp_ready) begin
                bad++;
                $display("FAIL sb_req_ready: got %b want %b at %0t", req_ready, exp_ready, $time);
            end
            if (exp_ready != 3'b000) begin
                op = req_op[g*5 +: 5];
                a  = req_a[g*8 +: 8];
                b  = req_b[g*8 +: 8];
                total++;
                if ({alu_control, alu_input1, alu_input2, alu_carry_in} !== {op, a, b, m_carry[g]}) begin
                    bad++;
                    $display("FAIL sb_alu_drive: got op=%0d a=%h b=%h cin=%b want op=%0d a=%h b=%h cin=%b at %0t",
                             alu_control, alu_input1, alu_input2, alu_carry_in, op, a, b, m_carry[g], $time);
                end
                r = alu_ref(op, a, b, m_carry[g]);
                sb_q.push_back({2'(g), r[11:8], r[7:0]});
                if (op <= 5'd3) m_carry[g] = r[9];
                m_ptr  = (g == 2) ? 2'd0 : 2'(g + 1);
                m_full = 1'b1;
                m_pend = 1'b1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; req_valid = 3'b111; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_flags} !== 15'd0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%b id=%0d data=%h flags=%h want all 0", rsp_valid, rsp_id, rsp_data, rsp_flags);
        end
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 3'b000;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 3; i++) set_req(i, 5'd4, 8'(8'h11 * (i + 1)), 8'hFF);
        @(posedge clk); #1;
        req_valid = 3'b111; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 3'(1 << (i % 3))) begin
                bad++;
                $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 3'(1 << (i % 3)));
            end
            if (i > 0) begin
                total++;
                if (rsp_id !== 2'((i - 1) % 3)) begin
                    bad++;
                    $display("FAIL rr_rsp_id%0d: got %0d want %0d", i, rsp_id, (i - 1) % 3);
                end
            end
            @(posedge clk); #1;
            if (i == 3) req_valid = 3'b000;
        end
        @(negedge clk);
        total++;
        if (rsp_id !== 2'd0) begin bad++; $display("FAIL rr_rsp_id4: got %0d want 0", rsp_id); end
    endtask

    task automatic test_carry_chain();
        @(posedge clk); #1;
        set_req(1, 5'd0, 8'hFF, 8'h01); req_valid = 3'b010;
        @(posedge clk); #1;
        set_req(1, 5'd2, 8'h00, 8'h00);
        @(negedge clk);
        total++;
        if (rsp_data !== 8'h00 || rsp_flags[1] !== 1'b1) begin
            bad++;
            $display("FAIL chain_add: got data=%h carry=%b want data=00 carry=1", rsp_data, rsp_flags[1]);
        end
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (rsp_data !== 8'h01) begin bad++; $display("FAIL chain_addc: got %h want 01", rsp_data); end
    endtask

    task automatic test_carry_isolation();
        @(posedge clk); #1;
        set_req(0, 5'd0, 8'hFF, 8'h01); req_valid = 3'b001;
        @(posedge clk); #1;
        set_req(2, 5'd2, 8'h00, 8'h00); req_valid = 3'b100;
        @(posedge clk); #1;
        set_req(0, 5'd2, 8'h00, 8'h00); req_valid = 3'b001;
        @(negedge clk);
        total++;
        if (rsp_id !== 2'd2 || rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL iso_req2: got id=%0d data=%h want id=2 data=00", rsp_id, rsp_data);
        end
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (rsp_id !== 2'd0 || rsp_data !== 8'h01) begin
            bad++;
            $display("FAIL iso_req0: got id=%0d data=%h want id=0 data=01", rsp_id, rsp_data);
        end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(0, 5'd6, 8'h5A, 8'h0F); req_valid = 3'b001;
        @(posedge clk); #1;
        set_req(2, 5'd5, 8'h30, 8'h03); req_valid = 3'b100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 3'b000 || rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_id !== 2'd0) begin
                bad++;
                $display("FAIL stall_hold%0d: got rdy=%b v=%b data=%h id=%0d want rdy=000 v=1 data=55 id=0",
                         i, req_ready, rsp_valid, rsp_data, rsp_id);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 3'b100) begin bad++; $display("FAIL stall_release_rdy: got %b want 100", req_ready); end
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h33 || rsp_id !== 2'd2) begin
            bad++;
            $display("FAIL stall_overwrite: got v=%b data=%h id=%0d want v=1 data=33 id=2", rsp_valid, rsp_data, rsp_id);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h33) begin
            bad++;
            $display("FAIL pop_only: got v=%b data=%h want v=0 data=33", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_sub();
        @(posedge clk); #1;
        set_req(0, 5'd1, 8'h05, 8'h05); req_valid = 3'b001;
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (rsp_data !== 8'h00 || rsp_flags[1:0] !== 2'b11) begin
            bad++;
            $display("FAIL sub_equal: got data=%h flags=%b want data=00 flags[1:0]=11", rsp_data, rsp_flags);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1, 5'd0, 8'hFF, 8'h01); req_valid = 3'b010;
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_flags[1] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_setup: got v=%b carry=%b want v=1 carry=1", rsp_valid, rsp_flags[1]);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; rsp_ready = 1'b1;
        set_req(1, 5'd2, 8'h01, 8'h01); req_valid = 3'b010;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_flush: got v=%b want 0", rsp_valid); end
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h02) begin
            bad++;
            $display("FAIL midrst_addc: got v=%b data=%h want v=1 data=02", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                set_req(i, 5'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
            end
            req_valid = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = 3'b000; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (sb_q.size() != 0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: got queue=%0d v=%b want queue=0 v=0", sb_q.size(), rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_carry_chain();
        test_carry_isolation();
        test_stall();
        test_sub();
        test_reset_mid();
        test_back_to_back();
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
